// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: Set-2 digit scan codes, the break prefix and
// the frame-level helpers used by the keystroke emulator.
package ps2_pkg;

  localparam logic [7:0] SC_0          = 8'h45;
  localparam logic [7:0] SC_1          = 8'h16;
  localparam logic [7:0] SC_2          = 8'h1E;
  localparam logic [7:0] SC_3          = 8'h26;
  localparam logic [7:0] SC_4          = 8'h25;
  localparam logic [7:0] SC_5          = 8'h2E;
  localparam logic [7:0] SC_6          = 8'h36;
  localparam logic [7:0] SC_7          = 8'h3D;
  localparam logic [7:0] SC_8          = 8'h3E;
  localparam logic [7:0] SC_9          = 8'h46;
  localparam logic [7:0] SC_BREAK      = 8'hF0;
  localparam logic [7:0] DIGIT_INVALID = 8'd47;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } ps2_state_e;

  // Out-of-range digits map to DIGIT_INVALID, which is never a legal make code.
  function automatic logic [7:0] digit_to_scan(input logic [7:0] digit);
    case (digit)
      8'd0:    return SC_0;
      8'd1:    return SC_1;
      8'd2:    return SC_2;
      8'd3:    return SC_3;
      8'd4:    return SC_4;
      8'd5:    return SC_5;
      8'd6:    return SC_6;
      8'd7:    return SC_7;
      8'd8:    return SC_8;
      8'd9:    return SC_9;
      default: return DIGIT_INVALID;
    endcase
  endfunction

  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_byte_tx.sv
// Serialises one byte as an 11-bit device-to-host PS/2 frame; done marks
// the clock edge that ends the stop bit.
module ps2_byte_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] data_byte,
  output logic       done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  ps2_state_e      state_r;
  logic [HW-1:0]   half_r;
  logic            low_r;
  logic [2:0]      bit_r;
  logic [7:0]      shift_r;
  logic            parity_r;
  logic            ps2_clk_r;
  logic            ps2_data_r;
  logic            half_end_s;
  logic            bit_end_s;

  // Half-period and bit boundary decode.
  always_comb begin
    half_end_s = (half_r == HW'(CLK_DIV - 1));
    bit_end_s  = half_end_s && low_r;
    done       = (state_r == ST_STOP) && bit_end_s;
  end

  // Frame FSM: data changes only at bit start, while the clock is high.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      half_r     <= {HW{1'b0}};
      low_r      <= 1'b0;
      bit_r      <= 3'd0;
      shift_r    <= 8'h00;
      parity_r   <= 1'b0;
      ps2_clk_r  <= 1'b1;
      ps2_data_r <= 1'b1;
    end else if (state_r == ST_IDLE) begin
      if (start) begin
        state_r    <= ST_START;
        half_r     <= {HW{1'b0}};
        low_r      <= 1'b0;
        bit_r      <= 3'd0;
        shift_r    <= data_byte;
        parity_r   <= odd_parity(data_byte);
        ps2_clk_r  <= 1'b1;
        ps2_data_r <= 1'b0;
      end
    end else if (!half_end_s) begin
      half_r <= half_r + HW'(1);
    end else if (!low_r) begin
      half_r    <= {HW{1'b0}};
      low_r     <= 1'b1;
      ps2_clk_r <= 1'b0;
    end else begin
      half_r    <= {HW{1'b0}};
      low_r     <= 1'b0;
      ps2_clk_r <= 1'b1;
      case (state_r)
        ST_START: begin
          state_r    <= ST_DATA;
          ps2_data_r <= shift_r[0];
        end
        ST_DATA: begin
          if (bit_r == 3'd7) begin
            state_r    <= ST_PARITY;
            ps2_data_r <= parity_r;
          end else begin
            bit_r      <= bit_r + 3'd1;
            shift_r    <= {1'b0, shift_r[7:1]};
            ps2_data_r <= shift_r[1];
          end
        end
        ST_PARITY: begin
          state_r    <= ST_STOP;
          ps2_data_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_IDLE;
          ps2_data_r <= 1'b1;
        end
      endcase
    end
  end

  assign ps2_clk  = ps2_clk_r;
  assign ps2_data = ps2_data_r;

endmodule

// File: rtl/key_encode_tx.sv
// Keyboard emulator: accepts a decimal digit and transmits make / F0 / make
// on the PS/2 lines, with idle gaps after each byte.
module key_encode_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] number,
  input  logic       valid,
  output logic       ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    KEY_IDLE  = 2'd0,
    KEY_FRAME = 2'd1,
    KEY_GAP   = 2'd2
  } key_state_e;

  key_state_e    state_r;
  logic [1:0]    idx_r;
  logic [GW-1:0] gap_r;
  logic [7:0]    code_r;
  logic          ready_r;
  logic          busy_r;
  logic          err_r;
  logic [7:0]    scan_s;
  logic          accept_s;
  logic          gap_end_s;
  logic          tx_start_s;
  logic [7:0]    tx_byte_s;
  logic          tx_done_s;

  // The first byte starts on the accept edge itself, so it bypasses code_r.
  always_comb begin
    scan_s     = digit_to_scan(number);
    accept_s   = valid && ready_r;
    gap_end_s  = (state_r == KEY_GAP) && (gap_r == GW'(GAP_CYCLES - 1));
    tx_start_s = 1'b0;
    tx_byte_s  = code_r;
    if (accept_s && (scan_s != DIGIT_INVALID)) begin
      tx_start_s = 1'b1;
      tx_byte_s  = scan_s;
    end else if (gap_end_s && (idx_r != 2'd2)) begin
      tx_start_s = 1'b1;
      tx_byte_s  = (idx_r == 2'd0) ? SC_BREAK : code_r;
    end else begin
      tx_start_s = 1'b0;
      tx_byte_s  = code_r;
    end
  end

  ps2_byte_tx #(
    .CLK_DIV  (CLK_DIV)
  ) u_byte_tx (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (tx_start_s),
    .data_byte(tx_byte_s),
    .done     (tx_done_s),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  // Keystroke sequencer: handshake, byte index and inter-byte gap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= KEY_IDLE;
      idx_r   <= 2'd0;
      gap_r   <= {GW{1'b0}};
      code_r  <= 8'h00;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        KEY_IDLE: begin
          if (accept_s) begin
            if (scan_s == DIGIT_INVALID) begin
              err_r <= 1'b1;
            end else begin
              code_r  <= scan_s;
              idx_r   <= 2'd0;
              state_r <= KEY_FRAME;
              ready_r <= 1'b0;
              busy_r  <= 1'b1;
            end
          end
        end
        KEY_FRAME: begin
          if (tx_done_s) begin
            state_r <= KEY_GAP;
            gap_r   <= {GW{1'b0}};
          end
        end
        KEY_GAP: begin
          if (gap_end_s) begin
            if (idx_r == 2'd2) begin
              state_r <= KEY_IDLE;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              idx_r   <= idx_r + 2'd1;
              state_r <= KEY_FRAME;
            end
          end else begin
            gap_r <= gap_r + GW'(1);
          end
        end
        default: begin
          state_r <= KEY_IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_r;
  assign busy  = busy_r;
  assign err   = err_r;

endmodule

// File: doc/key_encode_tx.md
Name: key_encode_tx

Overview:
Inverse of the keypad scan-code decoder: accepts a decimal digit 0-9 over a valid/ready handshake and maps it to its PS/2 Set-2 make code. Emits a full device-to-host keystroke on PS/2 clock/data lines: make code, break prefix F0, make code.
Used as a keyboard emulator for loopback testing of the calculator's PS/2 receive path and for scripted key entry.

Parameters:
CLK_DIV, 4, Clk cycles per PS/2 clock half-period (high phase = low phase = CLK_DIV); must be >= 2.
GAP_CYCLES, 8, idle Clk cycles (both lines high) after every transmitted byte; must be >= 1.

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
number  in  8  digit to send, binary 0-9; 10-255 invalid
valid  in  1  number valid
ready  out  1  block idle, can accept
ps2_clk  out  1  emulated PS/2 clock, idle high
ps2_data  out  1  emulated PS/2 data, idle high
busy  out  1  keystroke transmission in progress
err  out  1  one-cycle pulse: invalid digit rejected

Behaviour:
- Reset (sync, active-high, overrides everything including mid-frame): next edge -> state IDLE, ps2_clk=1, ps2_data=1, busy=0, err=0, ready=1. Any in-flight frame is abandoned, not completed.
- Accept: valid && ready at rising edge T. number is latched at T; later changes are ignored. valid while ready=0 is ignored, with no queueing.
- Code map: 0->45, 1->16, 2->1E, 3->26, 4->25, 5->2E, 6->36, 7->3D, 8->3E, 9->46 (hex).
- Invalid number (>9) at accept: no frames, lines stay high, busy stays 0, err=1 for cycle T+1 only, ready stays 1.
- Valid number: from T+1, busy=1 and ready=0. Three bytes are sent in order: CODE, F0, CODE.
- Byte frame: 11 bits = start 0, data[0..7] LSB first, odd parity (data plus parity has an odd number of ones), stop 1.
- Bit timing: each bit lasts 2*CLK_DIV cycles. ps2_data updates at the first cycle of the bit, while ps2_clk is high. ps2_clk is high for CLK_DIV cycles, then low for CLK_DIV cycles. The host samples on the falling edge.
- Byte = 22*CLK_DIV cycles, followed by GAP_CYCLES with both lines high. The first byte's start bit appears at T+1.
- Total busy span = 3*(22*CLK_DIV+GAP_CYCLES) cycles, covering T+1 to T+S where S is that span. At T+S+1: busy=0, ready=1. With defaults, S=288.
- A new accept is possible in the same cycle ready returns to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - Byte index 0..2 selects CODE/F0/CODE.
  - GAP with index 2 -> IDLE; otherwise index++ -> START.
  - Bit counter 0..7 in DATA. Half-period counter 0..CLK_DIV-1 throughout.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package ps2_pkg:
  - scan-code constants SC_0..SC_9 and SC_BREAK=8'hF0;
  - DIGIT_INVALID=8'd47, the decoder's invalid marker;
  - function digit_to_scan(8-bit)->8-bit.
- Sub-module ps2_byte_tx: serialises one byte with start/parity/stop and timing (CLK_DIV).
  - Interface: start pulse, byte in, done pulse, ps2_clk/ps2_data out.
  - key_encode_tx sequences three bytes through it and owns the gap timing and handshake.

Test Plan:
- Reset with idle lines: assert Reset 3 cycles -> ps2_clk=1, ps2_data=1, ready=1, busy=0, err=0.
- Send digit 5 (defaults): accept at T. Sampling ps2_data on each ps2_clk fall gives 0,0,1,1,1,0,1,0,0,1,1 (2E, parity 1), then F0 frame 0,0,0,0,0,1,1,1,1,1,1, then the 2E frame again. busy=0 and ready=1 exactly at T+289.
- Send digit 0, then digit 1 back-to-back (valid held high): the 45 stream has parity 0, the second accept lands the cycle ready returns, and the 16 stream has parity 0. No extra gap between keystrokes.
- Invalid number 10: err=1 only at T+1. Lines stay high, busy=0, ready=1 throughout.
- Reset mid-frame: Reset during DATA bit 3 of the F0 byte -> next edge lines high, ready=1. A following digit 9 produces a clean 46/F0/46 sequence.
- valid during busy with number=7: ignored. No 3D frames appear, and the current keystroke completes unchanged.
